rsa_stream_decryptor: RTL and testbench

Receive-side counterpart of the RSA encryption path. It accepts 16-bit ciphertext words over a valid/ready stream and computes plaintext = cipher^d mod n with a constant-time, left-to-right square-and-multiply engine. The private key (d, n) comes from the decryption key generator. Plaintext is returned on a second valid/ready stream with an error sideband.

---
 rtl/rsa_stream_decryptor.sv | 203 ++++++++++++++++++++
 tb/tb_rsa_stream_decryptor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_stream_decryptor.sv
// rsa_stream_decryptor: plaintext = cipher^d mod n, constant-time left-to-right square-and-multiply.
// Latency: handshake cycle T -> plain_valid in cycle T+3+2*WIDTH*(WIDTH+1) (T+547 at WIDTH=16); operand error -> T+2.
// Backpressure: one word in flight; cipher_ready only in IDLE; the result is held in OUT until plain_ready.
// Ports: clk/reset (async, active-high); key_load, d_in, n_in load the private key while idle;
//        cipher_valid/cipher_ready/cipher_data form the input stream;
//        plain_valid/plain_ready/plain_data/plain_err form the output stream; busy = not IDLE.
module rsa_stream_decryptor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_load,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] n_in,
  input  logic             cipher_valid,
  output logic             cipher_ready,
  input  logic [WIDTH-1:0] cipher_data,
  output logic             plain_valid,
  input  logic             plain_ready,
  output logic [WIDTH-1:0] plain_data,
  output logic             plain_err,
  output logic             busy
);

  localparam int RW = WIDTH + 2;           // multiplier datapath width: 2r + a < 3n
  localparam int CW = $clog2(WIDTH + 1);   // multiplier step counter (load + WIDTH iterations)
  localparam int IW = $clog2(WIDTH);       // exponent bit index

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR,
    S_MUL,
    S_DONE,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] kd_q, kd_d;       // loaded key
  logic [WIDTH-1:0] kn_q, kn_d;
  logic [WIDTH-1:0] op_d_q, op_d_d;   // key snapshot used by the word in flight
  logic [WIDTH-1:0] op_n_q, op_n_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [RW-1:0]    r_q, r_d;         // multiplier partial remainder
  logic [WIDTH-1:0] mb_q, mb_d;       // multiplier operand, shifted out MSB-first
  logic [CW-1:0]    mcnt_q, mcnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             perr_q, perr_d;

  // One interleaved shift-add step: r = 2r + (bit ? a : 0), then up to two subtractions of n.
  // The multiplicand is acc for squaring and c for the multiply step; the multiplier is always acc.
  logic [WIDTH-1:0] mul_a;
  logic [RW-1:0]    n_ext, t0, t1, r_iter;

  always_comb begin
    mul_a  = (state_q == S_SQR) ? acc_q : c_q;
    n_ext  = {2'b00, op_n_q};
    t0     = (r_q << 1) + (mb_q[WIDTH-1] ? {2'b00, mul_a} : '0);
    t1     = (t0 >= n_ext) ? (t0 - n_ext) : t0;
    r_iter = (t1 >= n_ext) ? (t1 - n_ext) : t1;
  end

  always_comb begin
    state_d = state_q;
    kd_d    = kd_q;
    kn_d    = kn_q;
    op_d_d  = op_d_q;
    op_n_d  = op_n_q;
    c_d     = c_q;
    acc_d   = acc_q;
    r_d     = r_q;
    mb_d    = mb_q;
    mcnt_d  = mcnt_q;
    idx_d   = idx_q;
    pdata_d = pdata_q;
    perr_d  = perr_q;

    case (state_q)
      S_IDLE: begin
        if (key_load) begin
          kd_d = d_in;
          kn_d = n_in;
        end
        // The snapshot takes the current (old) key, so a same-cycle key_load affects only later words.
        if (cipher_valid && ready_q) begin
          c_d     = cipher_data;
          op_d_d  = kd_q;
          op_n_d  = kn_q;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((op_n_q < WIDTH'(2)) || (c_q >= op_n_q)) begin
          pdata_d = '0;
          perr_d  = 1'b1;
          state_d = S_OUT;
        end else begin
          acc_d   = WIDTH'(1);
          idx_d   = IW'(WIDTH - 1);
          mcnt_d  = '0;
          state_d = S_SQR;
        end
      end

      S_SQR, S_MUL: begin
        if (mcnt_q == '0) begin
          r_d    = '0;
          mb_d   = acc_q;
          mcnt_d = CW'(1);
        end else begin
          r_d  = r_iter;
          mb_d = mb_q << 1;
          if (mcnt_q == CW'(WIDTH)) begin
            mcnt_d = '0;
            if (state_q == S_SQR) begin
              acc_d   = r_iter[WIDTH-1:0];
              state_d = S_MUL;
            end else begin
              // The product is always computed; only its use depends on the exponent bit.
              if (op_d_q[idx_q]) begin
                acc_d = r_iter[WIDTH-1:0];
              end
              if (idx_q == '0) begin
                state_d = S_DONE;
              end else begin
                idx_d   = idx_q - IW'(1);
                state_d = S_SQR;
              end
            end
          end else begin
            mcnt_d = mcnt_q + CW'(1);
          end
        end
      end

      S_DONE: begin
        pdata_d = acc_q;
        perr_d  = 1'b0;
        state_d = S_OUT;
      end

      S_OUT: begin
        if (plain_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next state, so they are 0 while in reset.
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kd_q    <= '0;
      kn_q    <= '0;
      op_d_q  <= '0;
      op_n_q  <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      mb_q    <= '0;
      mcnt_q  <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      pdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kd_q    <= kd_d;
      kn_q    <= kn_d;
      op_d_q  <= op_d_d;
      op_n_q  <= op_n_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      mb_q    <= mb_d;
      mcnt_q  <= mcnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      pdata_q <= pdata_d;
      perr_q  <= perr_d;
    end
  end

  assign cipher_ready = ready_q;
  assign plain_valid  = valid_q;
  assign plain_data   = pdata_q;
  assign plain_err    = perr_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_rsa_stream_decryptor.sv
// Testbench for rsa_stream_decryptor: scoreboard of expected words from a reference modexp model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure, latency, handshake timing, key-load ordering and mid-operation reset are exercised.
module tb_rsa_stream_decryptor;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_load;
  logic [15:0] d_in, n_in;
  logic        cipher_valid;
  logic        cipher_ready;
  logic [15:0] cipher_data;
  logic        plain_valid;
  logic        plain_ready;
  logic [15:0] plain_data;
  logic        plain_err;
  logic        busy;

  rsa_stream_decryptor #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_load    (key_load),
    .d_in        (d_in),
    .n_in        (n_in),
    .cipher_valid(cipher_valid),
    .cipher_ready(cipher_ready),
    .cipher_data (cipher_data),
    .plain_valid (plain_valid),
    .plain_ready (plain_ready),
    .plain_data  (plain_data),
    .plain_err   (plain_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    int          t_hs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] kd = 16'd0, kn = 16'd0;   // key the DUT should currently hold

  function automatic exp_t model(input logic [15:0] c, input logic [15:0] d,
                                 input logic [15:0] n, input int t);
    exp_t   e;
    longint r;
    e.t_hs = t;
    if (n < 16'd2 || c >= n) begin
      e.data = 16'd0;
      e.err  = 1'b1;
      e.lat  = 2;
    end else begin
      r = 1;
      for (int i = 15; i >= 0; i--) begin
        r = (r * r) % longint'(n);
        if (d[i]) r = (r * longint'(c)) % longint'(n);
      end
      e.data = r[15:0];
      e.err  = 1'b0;
      e.lat  = 547;
    end
    return e;
  endfunction

  // Output monitor: latency on the rising edge of plain_valid, data on consumption,
  // and the ready/valid state around consumption.
  logic prev_valid = 1'b0;
  logic chk_after  = 1'b0;
  always @(negedge clk) begin
    if (chk_after) begin
      check("post_consume_ready", cipher_ready, 1);
      check("post_consume_valid", plain_valid, 0);
      chk_after = 1'b0;
    end
    if (plain_valid && !prev_valid) begin
      if (sb.size() == 0) check("unexpected_output", 1, 0);
      else check("latency", cyc - sb[0].t_hs, sb[0].lat);
    end
    if (plain_valid && plain_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_consume", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("plain_data", plain_data, mon_e.data);
        check("plain_err", plain_err, mon_e.err);
        check("ready_in_out", cipher_ready, 0);
        chk_after = 1'b1;
      end
    end
    prev_valid = plain_valid;
  end

  task automatic load_key(input logic [15:0] d, input logic [15:0] n);
    bit ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) check("key_idle_timeout", 0, 1);
    @(posedge clk); #1;
    key_load = 1'b1; d_in = d; n_in = n;
    @(posedge clk); #1;
    key_load = 1'b0;
    kd = d; kn = n;
  endtask

  task automatic send_word(input logic [15:0] c, input bit ld = 0,
                           input logic [15:0] ld_d = 16'd0, input logic [15:0] ld_n = 16'd0);
    bit ok = 0;
    @(posedge clk); #1;
    cipher_valid = 1'b1;
    cipher_data  = c;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cipher_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("handshake_timeout", 0, 1);
      cipher_valid = 1'b0;
      return;
    end
    sb.push_back(model(c, kd, kn, cyc));
    if (ld) begin
      key_load = 1'b1; d_in = ld_d; n_in = ld_n;
    end
    @(posedge clk); #1;
    cipher_valid = 1'b0;
    key_load     = 1'b0;
    if (ld) begin kd = ld_d; kn = ld_n; end
    @(negedge clk);
    check("t1_ready_low", cipher_ready, 0);
    check("t1_busy", busy, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !plain_valid) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cipher_ready"}, cipher_ready, 0);
    check({tag, "_plain_valid"}, plain_valid, 0);
    check({tag, "_plain_data"}, plain_data, 0);
    check({tag, "_plain_err"}, plain_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached, expected completion earlier", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  exp_t bp_e;

  initial begin
    reset = 1'b1; key_load = 1'b0; d_in = '0; n_in = '0;
    cipher_valid = 1'b0; cipher_data = '0; plain_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: textbook key, 2790 -> 65
    load_key(16'd2753, 16'd3233);
    send_word(16'd2790);
    drain();

    // 2: back-to-back c=0 and c=1 with consumer always ready
    send_word(16'd0);
    send_word(16'd1);
    drain();

    // 3: d=0 gives 1; n=1 is an operand error
    load_key(16'd0, 16'd3233);
    send_word(16'd1234);
    drain();
    load_key(16'd5, 16'd1);
    send_word(16'd7);
    drain();

    // 4: c == n is an error, the following valid word is unaffected
    load_key(16'd2753, 16'd3233);
    send_word(16'd3233);
    send_word(16'd2790);
    drain();

    // key_load in the handshake cycle: in-flight word keeps the old key, next word sees n=1
    send_word(16'd2790, 1, 16'd7, 16'd1);
    send_word(16'd9);
    drain();

    // 5: consumer stalls 20 cycles; a cipher pulse during OUT must be ignored
    load_key(16'd2753, 16'd3233);
    @(posedge clk); #1;
    plain_ready = 1'b0;
    send_word(16'd1000);
    bp_e = sb[0];
    begin
      bit ok = 0;
      for (int k = 0; k < 700; k++) begin
        @(negedge clk);
        if (plain_valid) begin ok = 1; break; end
      end
      if (!ok) check("bp_valid_timeout", 0, 1);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      cipher_valid = (k == 5);
      cipher_data  = 16'd5;
      @(negedge clk);
      check("bp_valid_held", plain_valid, 1);
      check("bp_data_held", plain_data, bp_e.data);
      check("bp_ready_low", cipher_ready, 0);
    end
    @(posedge clk); #1;
    cipher_valid = 1'b0;
    plain_ready  = 1'b1;
    drain();

    // 6: reset 100 cycles into an exponentiation, keys cleared, then reload
    send_word(16'd2790);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    kd = 16'd0; kn = 16'd0;
    send_word(16'd5);
    drain();
    load_key(16'd2753, 16'd3233);
    send_word(16'd2790);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
